// File: rtl/ext_pkg.sv
// ext_pkg: shared constants for the stream width extender.
//   EXT_MODE_ZERO / EXT_MODE_SIGN : encodings of the per-word in_sign input.
//   ext_width_ok()                : elaboration-time width sanity check.
package ext_pkg;

  localparam logic EXT_MODE_ZERO = 1'b0;
  localparam logic EXT_MODE_SIGN = 1'b1;

  // The output must be at least as wide as the input and the input non-empty.
  function automatic bit ext_width_ok(input int in_w, input int out_w);
    return (in_w >= 1) && (out_w >= in_w);
  endfunction

endpackage

// File: rtl/ext_skid_buf.sv
// ext_skid_buf: two-entry registered skid buffer (main M + skid S).
// Handshake: a transfer happens on a rising clk edge when valid & ready are
// both high on that side; valid never depends on ready, and in_ready_o is a
// pure register output (no combinational path from out_ready_i).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_valid_i    upstream word valid
//   in_ready_o    buffer can accept (skid entry empty)
//   in_data_i     upstream word (W bits)
//   out_valid_o   main entry holds a word
//   out_ready_i   downstream accepts
//   out_data_o    main entry contents, held when not valid
module ext_skid_buf #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] m_q, m_d, s_q, s_d;
  logic         m_v_q, m_v_d, s_v_q, s_v_d;
  logic         in_xfer, out_xfer;

  assign in_ready_o  = !s_v_q;
  assign out_valid_o = m_v_q;
  assign out_data_o  = m_q;

  assign in_xfer  = in_valid_i && !s_v_q;
  assign out_xfer = m_v_q && out_ready_i;

  always_comb begin
    m_d   = m_q;
    s_d   = s_q;
    m_v_d = m_v_q;
    s_v_d = s_v_q;
    if (s_v_q) begin
      // Full: input is blocked, a drain promotes the skid word.
      if (out_xfer) begin
        m_d   = s_q;
        s_v_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!m_v_q || out_xfer) begin
        // M empty or being drained this edge: new word replaces it.
        m_d   = in_data_i;
        m_v_d = 1'b1;
      end else begin
        s_d   = in_data_i;
        s_v_d = 1'b1;
      end
    end else if (out_xfer) begin
      // m_q keeps its value so out_data stays defined while idle.
      m_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q   <= '0;
      s_q   <= '0;
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      m_v_q <= m_v_d;
      s_v_q <= s_v_d;
    end
  end

endmodule

// File: rtl/ext_stream_unit.sv
// ext_stream_unit: valid/ready stream width extender IN_W -> OUT_W with
// per-word zero or sign extension, registered through a 2-entry skid buffer
// (1 word/cycle under backpressure, one cycle latency).
// Handshake: transfer on a rising clk edge when valid & ready are both high;
// valid is never a function of ready on the same side.
// Optional macro EXT_CNT_EN: out_cnt counts output transfers (wraps at
// 2^CNT_W); without it out_cnt is tied to 0.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_data [IN_W]      input word
//   in_sign             0 = zero-extend, 1 = sign-extend (sampled with in_data)
//   out_valid/out_ready output handshake
//   out_data [OUT_W]    extended word
//   out_cnt [CNT_W]     accepted-output count
module ext_stream_unit
  import ext_pkg::*;
#(
  parameter int IN_W  = 2,
  parameter int OUT_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);

  if (!ext_width_ok(IN_W, OUT_W)) begin : g_bad_width
    $error("ext_stream_unit: need IN_W >= 1 and OUT_W >= IN_W");
  end

  logic [OUT_W-1:0] ext_word;
  logic             fill_bit;

  // Bits above IN_W are all the fill bit; zero loop iterations when
  // OUT_W == IN_W, which makes the unit a plain register stage.
  always_comb begin
    fill_bit = (in_sign == EXT_MODE_SIGN) && in_data[IN_W-1];
    ext_word = '0;
    ext_word[IN_W-1:0] = in_data;
    for (int i = IN_W; i < OUT_W; i++) begin
      ext_word[i] = fill_bit;
    end
  end

  ext_skid_buf #(
    .W (OUT_W)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (ext_word),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
  );

`ifdef EXT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign out_cnt = cnt_q;
`else
  assign out_cnt = '0;
`endif

endmodule

// File: tb/tb_ext_stream_unit.sv
// Bench for ext_stream_unit: directed vectors with literal expectations plus
// a queue-based reference model checked every cycle on the falling edge.
module tb_ext_stream_unit;

  localparam int IN_W  = 2;
  localparam int OUT_W = 3;
  localparam int CNT_W = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (IN_W=2, OUT_W=3, CNT_W=2)
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_sign = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;

  // wide variant (IN_W=4, OUT_W=8)
  logic        in8_valid = 1'b0;
  logic        in8_ready;
  logic [3:0]  in8_data = '0;
  logic        in8_sign = 1'b0;
  logic        out8_valid;
  logic        out8_ready = 1'b0;
  logic [7:0]  out8_data;
  logic [15:0] out8_cnt;

  ext_stream_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  ext_stream_unit #(.IN_W(4), .OUT_W(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in8_valid), .in_ready(in8_ready), .in_data(in8_data), .in_sign(in8_sign),
    .out_valid(out8_valid), .out_ready(out8_ready), .out_data(out8_data), .out_cnt(out8_cnt)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic view of extension: a sign-mode word with the top input bit
  // set is the negative value, i.e. offset by 2^OUT_W - 2^IN_W.
  function automatic logic [OUT_W-1:0] model_ext(input int v, input logic s);
    int r;
    r = v;
    if (s && v >= (1 << (IN_W - 1))) r = v + (1 << OUT_W) - (1 << IN_W);
    return OUT_W'(r);
  endfunction

  // ---------------- reference model ----------------
  // Two-deep FIFO: accept when fewer than two words held, head is presented.
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_last;
  int               exp_cnt;
  bit               m_in_x, m_out_x;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_last = '0;
      exp_cnt  = 0;
    end else begin
      m_in_x  = in_valid && (exp_q.size() < 2);
      m_out_x = out_ready && (exp_q.size() > 0);
      if (m_out_x) begin
        exp_last = exp_q.pop_front();
        exp_cnt  = (exp_cnt + 1) % (1 << CNT_W);
      end
      if (m_in_x) exp_q.push_back(model_ext(int'(in_data), in_sign));
    end
  end

  // Transfer counter seen by the bench (for throughput check).
  int n_xfer = 0;
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) n_xfer++;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("mdl_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
      chk("mdl_in_ready",  32'(in_ready),  32'(exp_q.size() < 2));
      chk("mdl_out_data",  32'(out_data),  32'((exp_q.size() > 0) ? exp_q[0] : exp_last));
`ifdef EXT_CNT_EN
      chk("mdl_out_cnt",   32'(out_cnt),   32'(exp_cnt));
`else
      chk("mdl_out_cnt",   32'(out_cnt),   32'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic s);
    in_valid = v;
    in_data  = d;
    in_sign  = s;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [OUT_W-1:0] zexp [4];
  logic [OUT_W-1:0] sexp [4];
  logic [CNT_W-1:0] cexp [5];
  logic [IN_W-1:0]  dv;
  int               x0;

  initial begin
    zexp = '{3'b000, 3'b001, 3'b010, 3'b011};
    sexp = '{3'b000, 3'b001, 3'b110, 3'b111};
    cexp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_cnt",   32'(out_cnt),   32'd0);

    // extension sweep, zero then sign mode
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dv = IN_W'(i);
      drive(1'b1, dv, 1'b0);
      tick();
      chk("zero_valid", 32'(out_valid), 32'd1);
      chk("zero_data",  32'(out_data),  32'(zexp[i]));
    end
    for (int i = 0; i < 4; i++) begin
      dv = IN_W'(i);
      drive(1'b1, dv, 1'b1);
      tick();
      chk("sign_data", 32'(out_data), 32'(sexp[i]));
    end
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    chk("sweep_idle_valid", 32'(out_valid), 32'd0);
    chk("sweep_idle_hold",  32'(out_data),  32'b111);

    // backpressure
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 1'b0);
    tick();
    chk("bp_ready1", 32'(in_ready), 32'd1);
    chk("bp_data1",  32'(out_data), 32'b001);
    drive(1'b1, 2'b10, 1'b1);
    tick();
    chk("bp_ready2", 32'(in_ready), 32'd0);
    chk("bp_data2",  32'(out_data), 32'b001);
    drive(1'b1, 2'b11, 1'b1);
    tick();
    tick();
    chk("bp_stall_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_data",  32'(out_data), 32'b001);
    out_ready = 1'b1;
    tick();
    chk("bp_drain1", 32'(out_data), 32'b110);
    chk("bp_ready3", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drain2", 32'(out_data), 32'b111);
    drive(1'b0, '0, 1'b0);
    tick();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // full throughput: 8 words back to back
    x0 = n_xfer;
    for (int i = 0; i < 8; i++) begin
      dv = IN_W'(i);
      drive(1'b1, dv, i[2]);
      tick();
      chk("tp_in_ready",  32'(in_ready),  32'd1);
      chk("tp_out_valid", 32'(out_valid), 32'd1);
    end
    drive(1'b0, '0, 1'b0);
    tick();
    chk("tp_xfers", 32'(n_xfer - x0), 32'd8);
    tick();

    // transfer counter: 5 outputs after reset
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b1, 2'b01, 1'b0);
      else drive(1'b0, '0, 1'b0);
      tick();
      if (i >= 1) begin
`ifdef EXT_CNT_EN
        chk("cnt_seq", 32'(out_cnt), 32'(cexp[i-1]));
`else
        chk("cnt_tied", 32'(out_cnt), 32'd0);
`endif
      end
    end
    tick();

    // mid-operation asynchronous reset with both entries full
    out_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b0);
    tick();
    drive(1'b1, 2'b01, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_ready", 32'(in_ready),  32'd1);
    chk("async_rst_data",  32'(out_data),  32'd0);
    #2;
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 1'b1);
    tick();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data",  32'(out_data),  32'b111);
    drive(1'b0, '0, 1'b0);
    tick();

    // wide variant IN_W=4, OUT_W=8
    out8_ready = 1'b1;
    in8_valid  = 1'b1;
    in8_data   = 4'b1001;
    in8_sign   = 1'b1;
    tick();
    chk("w8_sign_valid", 32'(out8_valid), 32'd1);
    chk("w8_sign_data",  32'(out8_data),  32'hF9);
    in8_sign = 1'b0;
    tick();
    chk("w8_zero_data",  32'(out8_data),  32'h09);
    in8_valid = 1'b0;
    tick();
    chk("w8_idle", 32'(out8_valid), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_stream_unit.md
Name: ext_stream_unit

Overview:
- Parametrised, pipelined width extender for a valid/ready stream: widens IN_W-bit words to OUT_W bits with per-word zero- or sign-extension.
- Registered output with a 2-entry skid buffer, so it sustains 1 word/cycle under backpressure.
- Sits between narrow datapath producers (e.g. 2-bit operand generators) and wider arithmetic/FPGA-mapped stages.

Parameters:
- IN_W, 2, input word width; must be >= 1.
- OUT_W, 3, output word width; must be >= IN_W. IN_W == OUT_W gives a pass-through register.
- CNT_W, 16, width of the transfer counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  unit can accept a word this cycle
- in_data  in  IN_W  input word
- in_sign  in  1  extension mode for this word: 0 = zero-extend, 1 = sign-extend; sampled with in_data
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word this cycle
- out_data  out  OUT_W  extended word
- out_cnt  out  CNT_W  accepted-output count (only with EXT_CNT_EN)

Behaviour:
- Input transfer: in_valid & in_ready at a rising clk edge. Output transfer: out_valid & out_ready at a rising clk edge.
- Extension is combinational on the input side; the result is registered.
  - Zero mode: out = {(OUT_W-IN_W){1'b0}, in_data}.
  - Sign mode: upper bits replicate in_data[IN_W-1].
- Latency: a word accepted at edge N is presented on out_data/out_valid after edge N, so it is visible in cycle N+1.
- Storage is a main register (M) plus a skid register (S), with flags m_v and s_v. in_ready = !s_v, driven from a register with no combinational path from out_ready.
- Per-edge rules:
  - Input transfer with M empty, or with M being drained this edge: the word goes to M.
  - Input transfer with M full and not drained: the word goes to S and s_v sets.
  - Output transfer with s_v set: S moves to M and s_v clears.
  - Output transfer with no S and no input: m_v clears.
- Ordering: strict FIFO. Words are never dropped or duplicated.
- Simultaneous input and output transfer with only M full: M is replaced by the new word. Throughput is 1 word/cycle with no bubble.
- Full condition: s_v = 1, so in_ready = 0. in_valid is ignored and in_data/in_sign are don't-care.
- out_data holds stable while out_valid = 1 and out_ready = 0.
- Reset (asynchronous, any time including mid-transfer):
  - m_v = s_v = 0, out_valid = 0, in_ready = 1, out_data = 0, out_cnt = 0.
  - In-flight words are discarded.
  - First acceptance is possible at the first edge after rst deasserts.
- out_data is a don't-care when out_valid = 0, but is held at its last value (no X propagation).

Optional Feature:
- Macro: EXT_CNT_EN.
- Defined:
  - out_cnt increments by 1 on every output transfer and wraps from 2^CNT_W-1 to 0.
  - Reset value is 0.
- Undefined:
  - No counter logic. out_cnt is tied to 0 but the port still exists, so the interface is stable.

Decomposition:
- Package ext_pkg:
  - EXT_MODE_ZERO = 1'b0 and EXT_MODE_SIGN = 1'b1.
  - Width-check constant/function used to flag OUT_W < IN_W at elaboration.
- Sub-module ext_skid_buf (parametrised by data width): M/S registers and handshake. It carries OUT_W-bit already-extended words.
- Top level ext_stream_unit: extension logic, skid instance, optional counter.

Test Plan (defaults IN_W=2, OUT_W=3, CNT_W=16):
- Extension sweep, out_ready=1:
  - Zero mode, inputs 00, 01, 10, 11 -> 000, 001, 010, 011, one cycle later each.
  - Sign mode, same inputs -> 000, 001, 110, 111.
- Backpressure:
  - Stream 01 (zero), 10 (sign), 11 (sign) with out_ready=0 -> in_ready drops after the 2nd acceptance; the 3rd word is held off.
  - Then raise out_ready -> outputs 001, 110, 111 in order, with out_data stable while stalled.
- Full throughput: continuous in_valid/out_ready for 8 words -> 8 output transfers in 8 consecutive cycles, in_ready constantly 1.
- Mid-operation reset:
  - Assert rst asynchronously between edges with both registers full -> out_valid=0, in_ready=1, out_data=000 immediately.
  - The next word, 11 sign, outputs 111.
- EXT_CNT_EN with CNT_W=2: 5 output transfers -> out_cnt sequence 1, 2, 3, 0, 1. Without the macro, out_cnt is constantly 0.
- Parameter variant IN_W=4, OUT_W=8: sign-mode 4'b1001 -> 8'b11111001; zero-mode 4'b1001 -> 8'b00001001.
